// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 device-to-host frame receiver.
//
// Synchronises and glitch-filters the open-collector PS/2 clock/data pins,
// deserialises Set-2 frames (start, 8 data LSB-first, odd parity, stop) and
// presents good bytes on a valid/ready holding register.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   ps2_clk_in   PS/2 clock pin (asynchronous)
//   ps2_dat_in   PS/2 data pin (asynchronous)
//   rx_data      received byte, valid while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer takes the byte when rx_valid && rx_ready
//   rx_overrun   1-cycle pulse: good frame dropped, holding register full
//   err_parity   1-cycle pulse: odd-parity check failed
//   err_frame    1-cycle pulse: bad start or bad stop bit
//   err_timeout  1-cycle pulse: frame aborted by watchdog
//   busy         1 while a frame is in progress
//
// Optional feature macro: PS2_RX_TIMEOUT_EN enables the in-frame watchdog.
// Without it err_timeout is tied 0 and the FSM waits indefinitely.
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | waiting for a start bit
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | next strobe carries the parity bit
// STOP   | next strobe carries the stop bit; judge frame

module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [FILTER_LEN-2:0] hist_q, hist_d;
  logic [FILTER_LEN-1:0] hist_ext;
  logic filt_q, filt_d;
  logic all_lo, all_hi, strobe;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       good_q, good_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       busy_q;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ovr_q, ovr_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          tmo_q, tmo_d;
`endif

  // The history holds the FILTER_LEN-1 previous synchronised samples; together
  // with the current sample that gives FILTER_LEN consecutive samples.
  assign hist_ext = {hist_q, clk_sync_q};
  assign hist_d   = hist_ext[FILTER_LEN-2:0];
  assign all_lo   = !clk_sync_q && (hist_q == '0);
  assign all_hi   = clk_sync_q && (&hist_q);
  assign filt_d   = all_lo ? 1'b0 : (all_hi ? 1'b1 : filt_q);
  // Strobe fires in the cycle the filtered clock is about to fall.
  assign strobe   = filt_q && all_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      hist_q     <= '1;
      filt_q     <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      hist_q     <= hist_d;
      filt_q     <= filt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    good_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
    tmo_d     = 1'b0;
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (!dat_sync_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          parity_d = dat_sync_q;
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          ferr_d  = !dat_sync_q;
          perr_d  = !(^{shift_q, parity_q});
          good_d  = dat_sync_q && (^{shift_q, parity_q});
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_RX_TIMEOUT_EN
    // A strobe always restarts the watchdog, so an edge arriving exactly at
    // the limit still advances the frame.
    if (state_q == S_IDLE || strobe) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      tmo_d     = 1'b1;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      good_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      good_q    <= good_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
    end
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Holding register: a byte consumed in the same cycle a new one arrives
  // makes room for it, so only a truly full register overruns.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = 1'b0;
    if (good_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = ovr_q;
  assign err_parity = perr_q;
  assign err_frame  = ferr_q;
  assign busy       = busy_q;

endmodule
